settings_bus_master: RTL and testbench
======================================

# settings_bus_master

Single-beat command processor that drives the 8-bit-address settings bus and collects 32-bit readback values. It sits on `bus_clk` between a 64-bit AXI-stream command source (host DMA or control crossbar port) and a settings-bus responder such as the core global register bank. Each command beat is either a register write or an indexed readback. The block performs the settings-bus transaction, then returns exactly one 64-bit response beat per command.

## Interface
Parameters:
- `AWIDTH`, 8, settings-bus address width.
- `RB_SEL_ADDR`, 0, settings address of the responder's readback-select register.
- `RB_SEL_WIDTH`, 5, width of the readback index field.
- `RB_WAIT`, 2, cycles between readback-select strobe and rb_data sample. Legal range 1–15; 0 is illegal.

Ports:
- `bus_clk` in 1: single clock for all logic.
- `bus_rst_n` in 1: asynchronous, active-low reset.
- `cmd_tdata` in 64: command beat (format under Operation).
- `cmd_tvalid` in 1: command valid.
- `cmd_tlast` in 1: ignored; every beat is one command.
- `cmd_tready` out 1: command accepted.
- `resp_tdata` out 64: response beat.
- `resp_tvalid` out 1: response valid.
- `resp_tlast` out 1: tied to 1 whenever `resp_tvalid` is 1.
- `resp_tready` in 1: response consumed.
- `set_stb` out 1: settings-bus write strobe, one cycle wide.
- `set_addr` out AWIDTH: settings-bus address.
- `set_data` out 32: settings-bus data.
- `rb_data` in 32: responder readback value (combinational from the selected index).
- `busy` out 1: high in every state except IDLE.

## Operation
- Command fields:
  - [63:62] op: 00 = write, 01 = read, 10 and 11 = invalid.
  - [55:48] seq.
  - [AWIDTH+31:32] addr; for a read, [RB_SEL_WIDTH+31:32] is the readback index.
  - [31:0] data.
  - All other bits are ignored.
- Response fields:
  - [63:62] op, echoed.
  - [61] err.
  - [55:48] seq, echoed.
  - [31:0] payload: write = echoed data; read = captured rb_data; invalid = 0.
  - All other bits are 0.
- FSM states: IDLE, STROBE, WAIT, RESP.
- IDLE:
  - `cmd_tready`=1.
  - On handshake, latch op, seq, addr and data.
  - op 00 or 01 -> STROBE. Invalid op -> RESP with err=1.
- STROBE: `set_stb`=1 for this single cycle.
  - Write: `set_addr`=addr, `set_data`=data; next state RESP.
  - Read: `set_addr`=RB_SEL_ADDR, `set_data`={zero-extend, index}; next state WAIT with the counter loaded to RB_WAIT-1.
- WAIT:
  - Counter decrements each cycle.
  - At 0: capture `rb_data` into the payload on that edge and go to RESP.
- RESP:
  - `resp_tvalid`=1 and `resp_tdata` stays stable until `resp_tready`.
  - On handshake -> IDLE.
- `cmd_tready`=0 in every non-IDLE state; at most one command is outstanding.
- `set_addr`/`set_data` hold their last driven values when `set_stb`=0.
- Reset values: all outputs 0 (`cmd_tready`, `resp_tvalid`, `resp_tlast`, `resp_tdata`, `set_stb`, `set_addr`, `set_data`, `busy`); state IDLE; counter 0.
- `cmd_tready` rises in the first cycle after `bus_rst_n` deasserts.
- Reset asserted mid-operation:
  - Immediately clears state and outputs.
  - Any pending response is dropped.
  - A strobe cut by reset is not reissued.

## Timing
- Let T = cycle of the command handshake.
- Write: `set_stb` high in cycle T+1 only; `resp_tvalid` rises in T+2.
- Read:
  - `set_stb` high in T+1.
  - WAIT occupies T+2 .. T+1+RB_WAIT.
  - `rb_data` is sampled at the edge ending T+1+RB_WAIT.
  - `resp_tvalid` rises in T+2+RB_WAIT.
- Invalid op: no strobe; `resp_tvalid` rises in T+1.
- Response handshake in cycle R -> `cmd_tready`=1 in R+1. There is no combinational path from `resp_tready` to `cmd_tready`.
- Minimum spacing with `resp_tready` held high: write every 3 cycles; read every 3+RB_WAIT cycles.
- `resp_tready` held low: the block stalls in RESP indefinitely. `set_stb` stays low; `rb_data` changes after capture do not alter the payload.
- `cmd_tvalid` arriving during RESP is not accepted until IDLE.

## Test plan
- Write: cmd {op=00, seq=0x5A, addr=0x04, data=0x0000000A}, `resp_tready`=1 -> `set_stb` one cycle at T+1 with addr 0x04 and data 0x0000000A; `resp_tdata`=0x005A00000000000A at T+2; `resp_tlast`=1.
- Read with RB_WAIT=2: responder returns 0xACFF00 for index 2 one cycle after the select write; cmd {op=01, seq=0x11, index=2} -> strobe at T+1 with addr 0x00 and data 0x2; `resp_tdata`=0x40110000_00ACFF00 at T+4.
- Invalid op 11 with seq 0x7F -> no `set_stb`; `resp_tdata`=0xE07F000000000000 at T+1.
- Back-pressure: `resp_tready`=0 for 10 cycles while `cmd_tvalid` stays high and `rb_data` toggles -> `cmd_tready`=0 and `resp_tdata` stable throughout; the next command is accepted the cycle after the response handshake.
- Reset mid-read: deassert `bus_rst_n` during WAIT -> all outputs 0 immediately and no response is emitted; after release, a write completes normally with `resp_tvalid` at T+2.
- Stream of 8 alternating write/read commands with `resp_tready` randomized -> 8 responses in order, seq values echoed, exactly 8 `set_stb` pulses, writes every 3 cycles when unstalled.

Source files
------------

// File: rtl/settings_bus_master.sv
// settings_bus_master: single-beat command processor for the settings bus.
// Each 64-bit command beat performs one settings-bus write or one indexed
// readback, and produces exactly one 64-bit response beat.
module settings_bus_master #(
  parameter int unsigned AWIDTH       = 8,
  parameter int unsigned RB_SEL_ADDR  = 0,
  parameter int unsigned RB_SEL_WIDTH = 5,
  parameter int unsigned RB_WAIT      = 2
) (
  input  logic              bus_clk,
  input  logic              bus_rst_n,
  input  logic [63:0]       cmd_tdata,
  input  logic              cmd_tvalid,
  input  logic              cmd_tlast,
  output logic              cmd_tready,
  output logic [63:0]       resp_tdata,
  output logic              resp_tvalid,
  output logic              resp_tlast,
  input  logic              resp_tready,
  output logic              set_stb,
  output logic [AWIDTH-1:0] set_addr,
  output logic [31:0]       set_data,
  input  logic [31:0]       rb_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  // RB_WAIT is legal in 1..15, so the countdown fits in four bits.
  localparam logic [3:0] LP_WAIT_LOAD = 4'(RB_WAIT - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_cmd_tready;
  logic [1:0]          r_op;
  logic [7:0]          r_seq;
  logic [31:0]         r_payload;
  logic [AWIDTH-1:0]   r_set_addr;
  logic [31:0]         r_set_data;
  logic [3:0]          r_cnt;

  logic                w_cmd_hs;
  logic [1:0]          w_op_in;
  logic                w_op_in_valid;
  logic                w_is_read;
  logic [RB_SEL_WIDTH-1:0] w_rb_idx;
  logic                w_set_stb;
  logic                w_resp_tvalid;
  logic                w_busy;
  logic                w_unused;

  assign w_cmd_hs      = cmd_tvalid & r_cmd_tready;
  assign w_op_in       = cmd_tdata[63:62];
  assign w_op_in_valid = ~w_op_in[1];
  assign w_is_read     = (r_op == OP_READ);
  assign w_rb_idx      = cmd_tdata[RB_SEL_WIDTH+31:32];

  // tlast carries no meaning here and most command bits are reserved.
  assign w_unused = ^{cmd_tlast, cmd_tdata};

  // State register.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next_state  = r_state;
    w_set_stb     = 1'b0;
    w_resp_tvalid = 1'b0;
    w_busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_cmd_hs) begin
          w_next_state = w_op_in_valid ? S_STROBE : S_RESP;
        end
      end
      S_STROBE: begin
        w_set_stb    = 1'b1;
        w_next_state = w_is_read ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        w_resp_tvalid = 1'b1;
        if (resp_tready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Command latch, settings-bus drive registers, readback countdown/capture.
  // cmd_tready is registered from the next state so it is low during reset,
  // rises one cycle after release, and has no path from resp_tready.
  // Address/data are loaded on the handshake edge so they appear together
  // with set_stb, and are left untouched otherwise so they hold.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      r_cmd_tready <= 1'b0;
      r_op         <= '0;
      r_seq        <= '0;
      r_payload    <= '0;
      r_set_addr   <= '0;
      r_set_data   <= '0;
      r_cnt        <= '0;
    end else begin
      r_cmd_tready <= (w_next_state == S_IDLE);

      if (w_cmd_hs) begin
        r_op      <= w_op_in;
        r_seq     <= cmd_tdata[55:48];
        r_payload <= (w_op_in == OP_WRITE) ? cmd_tdata[31:0] : '0;
        if (w_op_in == OP_WRITE) begin
          r_set_addr <= cmd_tdata[AWIDTH+31:32];
          r_set_data <= cmd_tdata[31:0];
        end else if (w_op_in == OP_READ) begin
          r_set_addr <= AWIDTH'(RB_SEL_ADDR);
          r_set_data <= 32'(w_rb_idx);
        end
      end

      if (r_state == S_STROBE && w_is_read) begin
        r_cnt <= LP_WAIT_LOAD;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (r_state == S_WAIT && r_cnt == 4'd0) begin
        r_payload <= rb_data;
      end
    end
  end

  assign cmd_tready  = r_cmd_tready;
  assign resp_tvalid = w_resp_tvalid;
  assign resp_tlast  = w_resp_tvalid;
  assign resp_tdata  = {r_op, r_op[1], 5'b0, r_seq, 16'b0, r_payload};
  assign set_stb     = w_set_stb;
  assign set_addr    = r_set_addr;
  assign set_data    = r_set_data;
  assign busy        = w_busy;

endmodule

// File: tb/tb_settings_bus_master.sv
// Directed bench for settings_bus_master with a small readback responder.
module tb_settings_bus_master;

  logic        bus_clk = 1'b0;
  logic        bus_rst_n = 1'b0;
  logic [63:0] cmd_tdata = '0;
  logic        cmd_tvalid = 1'b0;
  logic        cmd_tlast = 1'b1;
  logic        cmd_tready;
  logic [63:0] resp_tdata;
  logic        resp_tvalid;
  logic        resp_tlast;
  logic        resp_tready = 1'b0;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] rb_data;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0]  r_rb_sel = '0;
  logic [31:0] rb_xor = '0;

  always #5 bus_clk = ~bus_clk;

  settings_bus_master #(
    .AWIDTH(8),
    .RB_SEL_ADDR(0),
    .RB_SEL_WIDTH(5),
    .RB_WAIT(2)
  ) dut (
    .bus_clk(bus_clk),
    .bus_rst_n(bus_rst_n),
    .cmd_tdata(cmd_tdata),
    .cmd_tvalid(cmd_tvalid),
    .cmd_tlast(cmd_tlast),
    .cmd_tready(cmd_tready),
    .resp_tdata(resp_tdata),
    .resp_tvalid(resp_tvalid),
    .resp_tlast(resp_tlast),
    .resp_tready(resp_tready),
    .set_stb(set_stb),
    .set_addr(set_addr),
    .set_data(set_data),
    .rb_data(rb_data),
    .busy(busy)
  );

  function automatic logic [31:0] rb_val(input logic [4:0] sel);
    if (sel == 5'd2) return 32'h00AC_FF00;
    return {16'hC0DE, 11'd0, sel};
  endfunction

  // Responder: select register written by a strobe to address 0.
  always @(posedge bus_clk) begin
    if (set_stb && set_addr == 8'h00) r_rb_sel <= set_data[4:0];
  end

  // Responder readback is combinational from the selected index.
  always_comb rb_data = rb_val(r_rb_sel) ^ rb_xor;

  function automatic logic [63:0] mk_cmd(input logic [1:0] op, input logic [7:0] seq,
                                         input logic [7:0] addr, input logic [31:0] data);
    return {op, 6'd0, seq, 8'd0, addr, data};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"},  64'(cmd_tready), 64'd0);
    check({tag, "_rv"},   64'(resp_tvalid), 64'd0);
    check({tag, "_rl"},   64'(resp_tlast), 64'd0);
    check({tag, "_rd"},   resp_tdata, 64'd0);
    check({tag, "_stb"},  64'(set_stb), 64'd0);
    check({tag, "_addr"}, 64'(set_addr), 64'd0);
    check({tag, "_data"}, 64'(set_data), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  function automatic logic [63:0] stream_cmd(input int i);
    if (i % 2 == 0) return mk_cmd(2'b00, 8'(8'h80 + i), 8'(8'h20 + i), 32'h1000_0000 + 32'(i));
    return mk_cmd(2'b01, 8'(8'h80 + i), 8'(i), 32'd0);
  endfunction

  function automatic logic [63:0] stream_exp(input int i);
    if (i % 2 == 0) return {2'b00, 6'd0, 8'(8'h80 + i), 16'd0, 32'h1000_0000 + 32'(i)};
    return {2'b01, 6'd0, 8'(8'h80 + i), 16'd0, rb_val(5'(i))};
  endfunction

  // Cycles between the first two accepted commands with responses always taken.
  task automatic measure_gap(input logic [1:0] op, output int gap);
    int t0 = -1;
    int t1 = -1;
    int cyc = 0;
    int k = 0;
    resp_tready = 1'b1;
    cmd_tvalid  = 1'b1;
    while (t1 < 0 && cyc < 40) begin
      cmd_tdata = mk_cmd(op, 8'(8'hA0 + k), 8'h30, 32'(k));
      if (cmd_tready) begin
        if (t0 < 0) t0 = cyc;
        else t1 = cyc;
        k++;
      end
      tick();
      cyc++;
    end
    cmd_tvalid = 1'b0;
    repeat (10) tick();
    gap = (t1 < 0) ? -1 : (t1 - t0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_bp;
    logic [63:0] exp_q[$];
    int n_acc;
    int n_resp;
    int n_stb;
    int gap;

    // Reset values and release.
    repeat (3) tick();
    check_all_zero("reset");
    bus_rst_n = 1'b1;
    check("rdy_in_release_cycle", 64'(cmd_tready), 64'd0);
    tick();
    check("rdy_after_release", 64'(cmd_tready), 64'd1);

    // Write.
    resp_tready = 1'b1;
    cmd_tdata = mk_cmd(2'b00, 8'h5A, 8'h04, 32'h0000_000A);
    cmd_tvalid = 1'b1;
    check("wr_rdy_T", 64'(cmd_tready), 64'd1);
    tick();
    cmd_tvalid = 1'b0;
    check("wr_stb_T1", 64'(set_stb), 64'd1);
    check("wr_addr", 64'(set_addr), 64'h04);
    check("wr_data", 64'(set_data), 64'h0A);
    check("wr_rv_T1", 64'(resp_tvalid), 64'd0);
    check("wr_rdy_T1", 64'(cmd_tready), 64'd0);
    tick();
    check("wr_stb_T2", 64'(set_stb), 64'd0);
    check("wr_rv_T2", 64'(resp_tvalid), 64'd1);
    check("wr_resp", resp_tdata, 64'h005A_0000_0000_000A);
    check("wr_tlast", 64'(resp_tlast), 64'd1);
    check("wr_addr_hold", 64'(set_addr), 64'h04);
    tick();
    check("wr_rv_after", 64'(resp_tvalid), 64'd0);
    check("wr_rdy_R1", 64'(cmd_tready), 64'd1);

    // Read, index 2.
    cmd_tdata = mk_cmd(2'b01, 8'h11, 8'h02, 32'h0);
    cmd_tvalid = 1'b1;
    tick();
    cmd_tvalid = 1'b0;
    check("rd_stb_T1", 64'(set_stb), 64'd1);
    check("rd_addr", 64'(set_addr), 64'h00);
    check("rd_data", 64'(set_data), 64'h2);
    tick();
    check("rd_busy_T2", 64'(busy), 64'd1);
    check("rd_rv_T2", 64'(resp_tvalid), 64'd0);
    check("rd_stb_T2", 64'(set_stb), 64'd0);
    tick();
    check("rd_rv_T3", 64'(resp_tvalid), 64'd0);
    tick();
    check("rd_rv_T4", 64'(resp_tvalid), 64'd1);
    check("rd_resp", resp_tdata, 64'h4011_0000_00AC_FF00);
    tick();
    check("rd_rdy_R1", 64'(cmd_tready), 64'd1);

    // Invalid op.
    cmd_tdata = mk_cmd(2'b11, 8'h7F, 8'h33, 32'hDEAD_BEEF);
    cmd_tvalid = 1'b1;
    tick();
    cmd_tvalid = 1'b0;
    check("inv_stb", 64'(set_stb), 64'd0);
    check("inv_rv_T1", 64'(resp_tvalid), 64'd1);
    check("inv_resp", resp_tdata, 64'hE07F_0000_0000_0000);
    check("inv_addr_hold", 64'(set_addr), 64'h00);
    tick();
    check("inv_rdy_R1", 64'(cmd_tready), 64'd1);

    // Back-pressure during a read response.
    resp_tready = 1'b0;
    cmd_tdata = mk_cmd(2'b01, 8'h22, 8'h03, 32'h0);
    cmd_tvalid = 1'b1;
    tick();
    cmd_tvalid = 1'b0;
    repeat (3) tick();
    exp_bp = 64'h4022_0000_C0DE_0003;
    check("bp_rv", 64'(resp_tvalid), 64'd1);
    check("bp_resp", resp_tdata, exp_bp);
    cmd_tdata = mk_cmd(2'b00, 8'h33, 8'h10, 32'h1234_5678);
    cmd_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rb_xor = $urandom | 32'h1;
      check("bp_rdy_low", 64'(cmd_tready), 64'd0);
      check("bp_resp_stable", resp_tdata, exp_bp);
      check("bp_stb_low", 64'(set_stb), 64'd0);
      tick();
    end
    rb_xor = '0;
    resp_tready = 1'b1;
    check("bp_rv_R", 64'(resp_tvalid), 64'd1);
    tick();
    check("bp_rdy_R1", 64'(cmd_tready), 64'd1);
    check("bp_rv_R1", 64'(resp_tvalid), 64'd0);
    tick();
    cmd_tvalid = 1'b0;
    check("bp_next_stb", 64'(set_stb), 64'd1);
    check("bp_next_addr", 64'(set_addr), 64'h10);
    check("bp_next_data", 64'(set_data), 64'h1234_5678);
    tick();
    check("bp_next_resp", resp_tdata, 64'h0033_0000_1234_5678);
    check("bp_next_rv", 64'(resp_tvalid), 64'd1);
    tick();

    // Reset asserted during WAIT.
    cmd_tdata = mk_cmd(2'b01, 8'h44, 8'h05, 32'h0);
    cmd_tvalid = 1'b1;
    tick();
    cmd_tvalid = 1'b0;
    tick();
    check("rst_mid_busy", 64'(busy), 64'd1);
    #2;
    bus_rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick();
    tick();
    bus_rst_n = 1'b1;
    check("rst_mid_rdy_release", 64'(cmd_tready), 64'd0);
    tick();
    check("rst_mid_rdy", 64'(cmd_tready), 64'd1);
    check("rst_mid_no_resp", 64'(resp_tvalid), 64'd0);
    cmd_tdata = mk_cmd(2'b00, 8'h55, 8'h08, 32'h0000_CAFE);
    cmd_tvalid = 1'b1;
    tick();
    cmd_tvalid = 1'b0;
    check("post_rst_stb", 64'(set_stb), 64'd1);
    check("post_rst_rv_T1", 64'(resp_tvalid), 64'd0);
    tick();
    check("post_rst_rv_T2", 64'(resp_tvalid), 64'd1);
    check("post_rst_resp", resp_tdata, 64'h0055_0000_0000_CAFE);
    tick();

    // Stream of alternating writes/reads with random response back-pressure.
    n_acc = 0;
    n_resp = 0;
    n_stb = 0;
    for (int cyc = 0; cyc < 400 && n_resp < 8; cyc++) begin
      if (n_acc < 8) begin
        cmd_tvalid = 1'b1;
        cmd_tdata  = stream_cmd(n_acc);
      end else begin
        cmd_tvalid = 1'b0;
      end
      resp_tready = 1'($urandom_range(0, 1));
      if (set_stb) n_stb++;
      if (cmd_tvalid && cmd_tready) begin
        exp_q.push_back(stream_exp(n_acc));
        n_acc++;
      end
      if (resp_tvalid && resp_tready) begin
        if (exp_q.size() == 0) check("stream_unexpected_resp", resp_tdata, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("stream_resp", resp_tdata, exp_q.pop_front());
        n_resp++;
      end
      tick();
    end
    cmd_tvalid = 1'b0;
    check("stream_n_resp", 64'(n_resp), 64'd8);
    check("stream_n_acc", 64'(n_acc), 64'd8);
    check("stream_n_stb", 64'(n_stb), 64'd8);

    // Throughput with responses always accepted.
    measure_gap(2'b00, gap);
    check("gap_write", 64'(gap), 64'd3);
    measure_gap(2'b01, gap);
    check("gap_read", 64'(gap), 64'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
